fetch_unit: RTL and testbench

Instruction-fetch stage of the rv32i pipeline. It consumes the branch redirect (PCSrcE, PCTargetE) and owns the architectural PC register. It issues one-outstanding-request fetches to instruction memory over a valid/ready handshake. It drives the IF/ID pipeline register, including stall hold and flush-on-redirect.

---
 rtl/fetch_unit.sv | 208 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the rv32i pipeline.
// Owns the architectural PC. Issues one fetch at a time to instruction
// memory over a valid/ready request channel with a separate response strobe.
// Drives the IF/ID pipeline register, including stall hold, bubbles and
// flush on a branch redirect.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   PCSrcE, PCTargetE branch redirect request and target (target bits [1:0] ignored)
//   StallD            hazard unit hold request for IF/ID
//   imem_req_valid    fetch request valid (registered)
//   imem_req_ready    memory accepts the request
//   imem_addr         word-aligned fetch address (registered)
//   imem_rsp_valid    response strobe, one per accepted request
//   imem_rsp_data     fetched instruction
//   InstrD, PCD, PCPlus4D, ValidD  IF/ID pipeline register contents
module fetch_unit #(
    parameter int unsigned    DPW       = 32,
    parameter logic [DPW-1:0] RESET_PC  = '0,
    parameter logic [31:0]    NOP_INSTR = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           PCSrcE,
    input  logic [DPW-1:0] PCTargetE,
    input  logic           StallD,
    output logic           imem_req_valid,
    input  logic           imem_req_ready,
    output logic [DPW-1:0] imem_addr,
    input  logic           imem_rsp_valid,
    input  logic [31:0]    imem_rsp_data,
    output logic [31:0]    InstrD,
    output logic [DPW-1:0] PCD,
    output logic [DPW-1:0] PCPlus4D,
    output logic           ValidD
);

    localparam logic [DPW-1:0] PC_STEP    = DPW'(4);
    localparam logic [DPW-1:0] RESET_ADDR = {RESET_PC[DPW-1:2], 2'b00};

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [DPW-1:0] pc_q, pc_d;
    logic [DPW-1:0] req_addr_q, req_addr_d;
    logic           drop_q, drop_d;
    logic           req_valid_q, req_valid_d;
    logic [31:0]    hold_instr_q, hold_instr_d;
    logic [DPW-1:0] hold_pc_q, hold_pc_d;

    logic [31:0]    instr_q, instr_d;
    logic [DPW-1:0] pcd_q, pcd_d;
    logic [DPW-1:0] pcp4_q, pcp4_d;
    logic           valid_q, valid_d;

    logic           handshake;
    logic [DPW-1:0] target;
    logic           deliver;
    logic [31:0]    dlv_instr;
    logic [DPW-1:0] dlv_pc;
    logic           unused_tgt_lsb;

    // Redirect targets are forced word aligned; the low bits carry no meaning.
    assign target         = {PCTargetE[DPW-1:2], 2'b00};
    assign unused_tgt_lsb = ^PCTargetE[1:0];

    assign handshake = (state_q == ST_REQ) && req_valid_q && imem_req_ready;

    // Next-state, PC bookkeeping and IF/ID update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        drop_d       = drop_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        deliver      = 1'b0;
        dlv_instr    = hold_instr_q;
        dlv_pc       = hold_pc_q;
        instr_d      = instr_q;
        pcd_d        = pcd_q;
        pcp4_d       = pcp4_q;
        valid_d      = valid_q;

        case (state_q)
            ST_REQ: begin
                if (handshake) begin
                    state_d = ST_WAIT;
                end
                // The request to the old address still goes out; its
                // response is dropped and the refetch comes from pc_q.
                if (PCSrcE) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end

            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (PCSrcE) begin
                        pc_d       = target;
                        req_addr_d = target;
                        drop_d     = 1'b0;
                        state_d    = ST_REQ;
                    end else if (drop_q) begin
                        drop_d     = 1'b0;
                        req_addr_d = pc_q;
                        state_d    = ST_REQ;
                    end else if (!StallD) begin
                        deliver    = 1'b1;
                        dlv_instr  = imem_rsp_data;
                        dlv_pc     = req_addr_q;
                        pc_d       = req_addr_q + PC_STEP;
                        req_addr_d = req_addr_q + PC_STEP;
                        state_d    = ST_REQ;
                    end else begin
                        hold_instr_d = imem_rsp_data;
                        hold_pc_d    = req_addr_q;
                        state_d      = ST_HOLD;
                    end
                end else if (PCSrcE) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end

            ST_HOLD: begin
                if (PCSrcE) begin
                    pc_d       = target;
                    req_addr_d = target;
                    state_d    = ST_REQ;
                end else if (!StallD) begin
                    deliver    = 1'b1;
                    dlv_instr  = hold_instr_q;
                    dlv_pc     = hold_pc_q;
                    pc_d       = hold_pc_q + PC_STEP;
                    req_addr_d = hold_pc_q + PC_STEP;
                    state_d    = ST_REQ;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase

        // IF/ID: flush beats delivery beats stall; otherwise insert a bubble.
        if (PCSrcE) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (deliver) begin
            instr_d = dlv_instr;
            pcd_d   = dlv_pc;
            pcp4_d  = dlv_pc + PC_STEP;
            valid_d = 1'b1;
        end else if (!StallD) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end

        req_valid_d = (state_d == ST_REQ);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_ADDR;
            req_addr_q   <= RESET_ADDR;
            drop_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= '0;
            instr_q      <= NOP_INSTR;
            pcd_q        <= '0;
            pcp4_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            drop_q       <= drop_d;
            req_valid_q  <= req_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            pcp4_q       <= pcp4_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = req_addr_q;
    assign InstrD         = instr_q;
    assign PCD            = pcd_q;
    assign PCPlus4D       = pcp4_q;
    assign ValidD         = valid_q;

    // A response is only legal while a request is outstanding.
    rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (state_q == ST_WAIT));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized bench for fetch_unit.
// The memory model answers each accepted request after a programmable
// latency with data = addr ^ 32'hA5A5_0000. A program-order model tracks the
// next PC that must be delivered: sequential +4, replaced by an aligned
// redirect target, with IF/ID flush/hold/bubble rules checked every edge.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .DPW       (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .StallD         (StallD),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD)
    );

    // Memory model state
    bit          mem_busy = 0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt  = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    bit          rnd_ready = 0;
    logic [31:0] blk_addr = '0;
    int          blk_left = 0;

    // Program-order model
    logic [31:0] exp_pc = '0;
    logic [31:0] acc_q[$];
    logic [31:0] del_q[$];

    // One clock cycle: advance memory model, check IF/ID and request channel.
    task automatic tick();
        logic p_rst, p_src, p_stall, p_valid, p_rdy, p_rsp, p_vd;
        logic [31:0] p_tgt, p_addr, p_instr, p_pcd, p_pcp4;
        p_rst   = rst;     p_src  = PCSrcE;   p_stall = StallD;  p_tgt = PCTargetE;
        p_valid = imem_req_valid; p_rdy = imem_req_ready; p_addr = imem_addr;
        p_rsp   = imem_rsp_valid;
        p_vd    = ValidD;  p_instr = InstrD;  p_pcd = PCD;  p_pcp4 = PCPlus4D;
        @(posedge clk);
        #1;
        if (p_rst) begin
            mem_busy = 0;
            exp_pc   = 32'h0;
        end else begin
            if (p_rsp) mem_busy = 0;
            if (p_valid && p_rdy) begin
                total++;
                if (mem_busy || p_addr[1:0] != 2'b00) begin
                    bad++;
                    $display("FAIL req_accept: busy=%0d addr=%h required idle and aligned", mem_busy, p_addr);
                end
                acc_q.push_back(p_addr);
                mem_busy = 1;
                mem_addr = p_addr;
                mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
            end else if (p_valid) begin
                total++;
                if (imem_req_valid !== 1'b1 || imem_addr !== p_addr) begin
                    bad++;
                    $display("FAIL req_hold: valid=%b addr=%h required 1 %h", imem_req_valid, imem_addr, p_addr);
                end
            end
            total++;
            if (p_src) begin
                if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== p_pcd || PCPlus4D !== p_pcp4) begin
                    bad++;
                    $display("FAIL flush: V=%b I=%h PCD=%h P4=%h required 0 %h %h %h", ValidD, InstrD, PCD, PCPlus4D, NOP, p_pcd, p_pcp4);
                end
                exp_pc = {p_tgt[31:2], 2'b00};
            end else if (p_stall) begin
                if (ValidD !== p_vd || InstrD !== p_instr || PCD !== p_pcd || PCPlus4D !== p_pcp4) begin
                    bad++;
                    $display("FAIL stall_hold: V=%b I=%h PCD=%h P4=%h required %b %h %h %h", ValidD, InstrD, PCD, PCPlus4D, p_vd, p_instr, p_pcd, p_pcp4);
                end
            end else if (ValidD === 1'b1) begin
                if (PCD !== exp_pc || PCPlus4D !== exp_pc + 32'd4 || InstrD !== (exp_pc ^ TAG)) begin
                    bad++;
                    $display("FAIL deliver: PCD=%h P4=%h I=%h required %h %h %h", PCD, PCPlus4D, InstrD, exp_pc, exp_pc + 32'd4, exp_pc ^ TAG);
                end
                del_q.push_back(PCD);
                exp_pc = exp_pc + 32'd4;
            end else begin
                if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== p_pcd || PCPlus4D !== p_pcp4) begin
                    bad++;
                    $display("FAIL bubble: V=%b I=%h PCD=%h P4=%h required 0 %h %h %h", ValidD, InstrD, PCD, PCPlus4D, NOP, p_pcd, p_pcp4);
                end
            end
        end
        // Drive memory outputs for the coming cycle.
        if (mem_busy && mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_addr ^ TAG;
        end else begin
            imem_rsp_valid = 1'b0;
            if (mem_busy) mem_cnt--;
        end
        if (blk_left > 0 && imem_req_valid === 1'b1 && imem_addr === blk_addr) begin
            imem_req_ready = 1'b0;
            blk_left--;
        end else begin
            imem_req_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    endtask

    task automatic wait_acc(input logic [31:0] a, input int bound, output bit hit);
        hit = 0;
        acc_q.delete();
        for (int i = 0; i < bound && !hit; i++) begin
            tick();
            if (acc_q.size() > 0 && acc_q[acc_q.size()-1] === a) hit = 1;
        end
    endtask

    task automatic wait_del(input int n, input int bound);
        for (int i = 0; i < bound && del_q.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; PCSrcE = 1'b0; StallD = 1'b0; PCTargetE = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        lat_min = 1; lat_max = 1; rnd_ready = 0;
        repeat (2) tick();
        total++; if (InstrD !== NOP) begin bad++; $display("FAIL rst_instr: %h required %h", InstrD, NOP); end
        total++; if (PCD !== 32'h0) begin bad++; $display("FAIL rst_pcd: %h required 0", PCD); end
        total++; if (PCPlus4D !== 32'h0) begin bad++; $display("FAIL rst_pcp4: %h required 0", PCPlus4D); end
        total++; if (ValidD !== 1'b0) begin bad++; $display("FAIL rst_valid: %b required 0", ValidD); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: %b required 0", imem_req_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: %h required 0", imem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        acc_q.delete(); del_q.delete();
        wait_del(3, 40);
        total++;
        if (del_q.size() < 3 || del_q[0] !== 32'h0 || del_q[1] !== 32'h4 || del_q[2] !== 32'h8) begin
            bad++; $display("FAIL seq_pcs: n=%0d first=%h required 0,4,8", del_q.size(), (del_q.size() > 0) ? del_q[0] : 32'hx);
        end
        total++;
        if (acc_q.size() < 3 || acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4 || acc_q[2] !== 32'h8) begin
            bad++; $display("FAIL seq_reqs: n=%0d required 0,4,8", acc_q.size());
        end
        total++;
        if (PCPlus4D !== 32'hC || InstrD !== (32'h8 ^ TAG)) begin
            bad++; $display("FAIL seq_third: P4=%h I=%h required c %h", PCPlus4D, InstrD, 32'h8 ^ TAG);
        end
    endtask

    task automatic test_ready_low();
        blk_addr = 32'h10; blk_left = 3;
        for (int i = 0; i < 60 && blk_left > 0; i++) tick();
        total++;
        if (blk_left != 0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h10) begin
            bad++; $display("FAIL ready_low: left=%0d valid=%b addr=%h required 0 1 10", blk_left, imem_req_valid, imem_addr);
        end
        acc_q.delete(); del_q.delete();
        wait_del(1, 20);
        total++;
        if (del_q.size() < 1 || del_q[0] !== 32'h10 || acc_q.size() != 1) begin
            bad++; $display("FAIL ready_low_deliver: ndel=%0d nacc=%0d required one 0x10", del_q.size(), acc_q.size());
        end
    endtask

    task automatic test_stall();
        bit hit;
        logic [31:0] s_instr, s_pcd;
        logic s_vd;
        wait_acc(32'h20, 40, hit);
        total++; if (!hit) begin bad++; $display("FAIL stall_req: 0x20 not requested"); end
        StallD = 1'b1;
        s_instr = InstrD; s_pcd = PCD; s_vd = ValidD;
        repeat (4) tick();
        total++;
        if (InstrD !== s_instr || PCD !== s_pcd || ValidD !== s_vd) begin
            bad++; $display("FAIL stall_keep: I=%h PCD=%h V=%b required %h %h %b", InstrD, PCD, ValidD, s_instr, s_pcd, s_vd);
        end
        StallD = 1'b0;
        tick();
        total++;
        if (ValidD !== 1'b1 || PCD !== 32'h20) begin
            bad++; $display("FAIL stall_release: V=%b PCD=%h required 1 20", ValidD, PCD);
        end
        wait_acc(32'h24, 10, hit);
        total++; if (!hit) begin bad++; $display("FAIL stall_next: 0x24 not requested"); end
    endtask

    task automatic test_redirect_wait();
        bit hit;
        lat_min = 3; lat_max = 3;
        wait_acc(32'h30, 60, hit);
        total++; if (!hit) begin bad++; $display("FAIL redir_wait_req: 0x30 not requested"); end
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        tick();
        PCSrcE = 1'b0; lat_min = 1; lat_max = 1;
        total++;
        if (ValidD !== 1'b0 || InstrD !== NOP) begin
            bad++; $display("FAIL redir_wait_flush: V=%b I=%h required 0 %h", ValidD, InstrD, NOP);
        end
        acc_q.delete(); del_q.delete();
        wait_del(1, 30);
        total++;
        if (acc_q.size() < 1 || acc_q[0] !== 32'h100 || del_q.size() < 1 || del_q[0] !== 32'h100) begin
            bad++; $display("FAIL redir_wait_target: nacc=%0d ndel=%0d required 0x100", acc_q.size(), del_q.size());
        end
    endtask

    task automatic test_redirect_hold();
        bit hit;
        wait_acc(32'h104, 20, hit);
        total++; if (!hit) begin bad++; $display("FAIL redir_hold_req: 0x104 not requested"); end
        StallD = 1'b1;
        repeat (3) tick();
        PCSrcE = 1'b1; PCTargetE = 32'h203;
        tick();
        PCSrcE = 1'b0; StallD = 1'b0;
        total++;
        if (ValidD !== 1'b0 || InstrD !== NOP) begin
            bad++; $display("FAIL redir_hold_flush: V=%b I=%h required 0 %h", ValidD, InstrD, NOP);
        end
        acc_q.delete(); del_q.delete();
        wait_del(1, 30);
        total++;
        if (acc_q.size() < 1 || acc_q[0] !== 32'h200 || del_q.size() < 1 || del_q[0] !== 32'h200) begin
            bad++; $display("FAIL redir_hold_target: nacc=%0d ndel=%0d required 0x200", acc_q.size(), del_q.size());
        end
    endtask

    task automatic test_wrap();
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        tick();
        PCSrcE = 1'b0;
        del_q.delete();
        wait_del(1, 30);
        total++;
        if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || ValidD !== 1'b1) begin
            bad++; $display("FAIL wrap_deliver: PCD=%h P4=%h V=%b required fffffffc 0 1", PCD, PCPlus4D, ValidD);
        end
        acc_q.delete(); del_q.delete();
        wait_del(1, 30);
        total++;
        if (acc_q.size() < 1 || acc_q[0] !== 32'h0 || del_q.size() < 1 || del_q[0] !== 32'h0) begin
            bad++; $display("FAIL wrap_next: nacc=%0d ndel=%0d required 0x0", acc_q.size(), del_q.size());
        end
    endtask

    task automatic test_random();
        rst = 1'b1; tick(); rst = 1'b0;
        rnd_ready = 1; lat_min = 1; lat_max = 3;
        del_q.delete();
        for (int i = 0; i < 3000; i++) begin
            StallD = ($urandom_range(3, 0) == 0);
            PCSrcE = ($urandom_range(11, 0) == 0);
            PCTargetE = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15, 0)) : $urandom;
            rst = (i == 1500);
            tick();
        end
        rst = 1'b0; PCSrcE = 1'b0; StallD = 1'b0;
        total++;
        if (del_q.size() < 50) begin
            bad++; $display("FAIL random_progress: deliveries=%0d required >=50", del_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ready_low();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
